ahb_slv_regmem_ctl: RTL

AHB slave responder for the NN calculator register/scratch memory. It is the slave end of the bus, connecting to the fabric slave port (sHSEL, sHTRANS, sHREADY, etc.). It accepts pipelined address/data phases and inserts a configurable number of wait states. It returns OKAY or a two-cycle ERROR response and stores 32-bit words in a small flop array.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_slv_mem.sv | 29 ++
 rtl/ahb_slv_regmem_ctl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave state type for the NN calculator register/scratch memory.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Only NONSEQ and SEQ beats carry a real transfer.
    function automatic logic isActiveTrans(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// DEPTH x 32 flop array: one synchronous write port, one combinational read port, cleared on reset.
module ahb_slv_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slv_regmem_ctl.sv
// AHB slave responder with configurable wait states and two-cycle ERROR responses.
// Optional build macro AHB_SLV_PROT_EN: user-mode writes (sHPROT[1]=0) are rejected with ERROR.
module ahb_slv_regmem_ctl
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        sHSEL,
    input  logic        sHREADYin,
    input  logic [31:0] sHADDR,
    input  logic [1:0]  sHTRANS,
    input  logic        sHWRITE,
    input  logic [2:0]  sHSIZE,
    input  logic [2:0]  sHBURST,
    input  logic [3:0]  sHPROT,
    input  logic [31:0] sHWDATA,
    output logic [31:0] sHRDATA,
    output logic        sHREADY,
    output logic [1:0]  sHRESP
);

    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slv_state_e    state_q, state_d;
    logic [2:0]    waitCnt_q, waitCnt_d;
    logic [AW-1:0] wordIdx_q, wordIdx_d;
    logic          isWrite_q, isWrite_d;

    logic          accept;
    logic          addrErr;
    logic          readyOut;
    logic [1:0]    respOut;
    logic          memWe;
    logic [31:0]   memRdata;
    logic          unusedInputs;

    assign unusedInputs = ^{sHBURST, sHPROT};

    always_comb begin
        addrErr = (sHSIZE != HSIZE_WORD) || (|sHADDR[1:0]) || (|sHADDR[31:AW+2]);
`ifdef AHB_SLV_PROT_EN
        addrErr = addrErr || (sHWRITE && !sHPROT[1]);
`endif
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            wordIdx_q <= '0;
            isWrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            wordIdx_q <= wordIdx_d;
            isWrite_q <= isWrite_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        wordIdx_d = wordIdx_q;
        isWrite_d = isWrite_q;
        readyOut  = 1'b1;
        respOut   = HRESP_OKAY;
        memWe     = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
            end
            ST_WAIT: begin
                readyOut = 1'b0;
                if (waitCnt_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    waitCnt_d = waitCnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                memWe = isWrite_q;
            end
            ST_ERR1: begin
                readyOut = 1'b0;
                respOut  = HRESP_ERROR;
                state_d  = ST_ERR2;
            end
            ST_ERR2: begin
                respOut = HRESP_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any ready state closes its data phase this cycle and may take a pipelined address phase.
        if (readyOut && (state_q inside {ST_IDLE, ST_DONE, ST_ERR2})) begin
            accept  = sHSEL && sHREADYin && isActiveTrans(sHTRANS);
            state_d = ST_IDLE;
            if (accept) begin
                wordIdx_d = sHADDR[AW+1:2];
                isWrite_d = sHWRITE;
                if (addrErr) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_d   = ST_WAIT;
                    waitCnt_d = WS_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    ahb_slv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (HCLK),
        .rst_ni  (HRESET),
        .we_i    (memWe),
        .waddr_i (wordIdx_q),
        .wdata_i (sHWDATA),
        .raddr_i (wordIdx_q),
        .rdata_o (memRdata)
    );

    assign sHREADY = readyOut;
    assign sHRESP  = respOut;
    assign sHRDATA = ((state_q == ST_DONE) && !isWrite_q) ? memRdata : 32'h0;

endmodule
